// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for mult_div_unit (MULTDIV_DIV_EN selects the divider)
package multdiv_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int ITER_COUNT    = DEFAULT_WIDTH;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MULT  = 3'd1,
    ST_DIV   = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/multdiv_addsub.sv
// rtl/multdiv_addsub.sv - (WIDTH+1)-bit adder/subtractor shared by the Booth and restoring steps
module multdiv_addsub
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0] x,
  input  logic [WIDTH:0] y,
  input  logic           sub,
  output logic [WIDTH:0] sum
);

  assign sum = sub ? (x - y) : (x + y);

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed Booth multiplier and restoring divider with HI/LO results
// Division datapath (DIV, FIXUP, div0) is built only when MULTDIV_DIV_EN is defined.
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  state_t           state;
  logic [5:0]       count;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             q_m1;
  logic             div0_r;

  logic [WIDTH:0]   as_x;
  logic [WIDTH:0]   as_y;
  logic [WIDTH:0]   as_sum;
  logic             as_sub;
  logic [WIDTH:0]   pre;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] q_next;

`ifdef MULTDIV_DIV_EN
  logic             sign_a;
  logic             sign_q;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
`endif

  multdiv_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x   (as_x),
    .y   (as_y),
    .sub (as_sub),
    .sum (as_sum)
  );

  // Accumulator is one bit wider so that subtracting the most negative
  // multiplicand cannot overflow during the Booth step.
  always_comb begin
    as_x     = acc;
    as_y     = {m[WIDTH-1], m};
    as_sub   = q[0] & ~q_m1;
    pre      = acc;
    acc_next = acc;
    q_next   = q;
    if (state == ST_MULT) begin
      pre      = (q[0] ^ q_m1) ? as_sum : acc;
      acc_next = {pre[WIDTH], pre[WIDTH:1]};
      q_next   = {pre[0], q[WIDTH-1:1]};
    end
`ifdef MULTDIV_DIV_EN
    else if (state == ST_DIV) begin
      as_x     = {acc[WIDTH-1:0], q[WIDTH-1]};
      as_y     = {1'b0, m};
      as_sub   = 1'b1;
      acc_next = as_sum[WIDTH] ? as_x : as_sum;
      q_next   = {q[WIDTH-2:0], ~as_sum[WIDTH]};
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      count  <= '0;
      acc    <= '0;
      q      <= '0;
      m      <= '0;
      q_m1   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      div0_r <= 1'b0;
`ifdef MULTDIV_DIV_EN
      sign_a <= 1'b0;
      sign_q <= 1'b0;
`endif
    end else begin
      div0_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            count <= '0;
            acc   <= '0;
            q_m1  <= 1'b0;
            if (op == OP_MULT) begin
              q     <= a;
              m     <= b;
              state <= ST_MULT;
            end else begin
`ifdef MULTDIV_DIV_EN
              q      <= a_mag;
              m      <= b_mag;
              sign_a <= a[WIDTH-1];
              sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
              if (b == '0) begin
                div0_r <= 1'b1;
                state  <= ST_DONE;
              end else begin
                state  <= ST_DIV;
              end
`else
              state <= ST_DONE;
`endif
            end
          end
        end
        ST_MULT: begin
          acc   <= acc_next;
          q     <= q_next;
          q_m1  <= q[0];
          count <= count + 6'd1;
          if (count == LAST_ITER) begin
            hi    <= acc_next[WIDTH-1:0];
            lo    <= q_next;
            state <= ST_DONE;
          end
        end
`ifdef MULTDIV_DIV_EN
        ST_DIV: begin
          acc   <= acc_next;
          q     <= q_next;
          count <= count + 6'd1;
          if (count == LAST_ITER) state <= ST_FIXUP;
        end
        // Quotient truncates toward zero; remainder follows the dividend sign.
        ST_FIXUP: begin
          hi    <= sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
          lo    <= sign_q ? -q : q;
          state <= ST_DONE;
        end
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_MULT) || (state == ST_DIV) || (state == ST_FIXUP);
  assign done = (state == ST_DONE);
  assign div0 = div0_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit (DIV cases need MULTDIV_DIV_EN)
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div0;

  int checks = 0;
  int passes = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .div0  (div0)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Cycle c=1 is the cycle right after the accepting edge.
  task automatic do_op(input string tag, input logic o, input logic [31:0] oa, input logic [31:0] ob,
                       input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input logic exp_div0, input int poke_at);
    int lat;
    int busy_cnt;
    logic hold_bad;
    logic d0;
    logic [31:0] h0;
    logic [31:0] l0;
    lat = 0; busy_cnt = 0; hold_bad = 1'b0; d0 = 1'b0; h0 = hi; l0 = lo;
    op = o; a = oa; b = ob; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin
        lat = c;
        d0 = div0;
        break;
      end
      if (busy) busy_cnt++;
      if (hi !== h0 || lo !== l0) hold_bad = 1'b1;
      if (c == poke_at) begin
        a = $urandom; b = $urandom; op = ~o; start = 1'b1;
      end
      if (c == poke_at + 1) start = 1'b0;
      @(posedge clock); #1;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
    check({tag, " div0"}, {63'd0, d0}, {63'd0, exp_div0});
    check({tag, " hold"}, {63'd0, hold_bad}, 64'd0);
    @(posedge clock); #1;
    check({tag, " after_done"}, {61'd0, done, div0, busy}, 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset hilo", {hi, lo}, 64'd0);
    check("reset flags", {61'd0, busy, done, div0}, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    do_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0);
    do_op("mul_max", 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 33, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 5);
    do_op("mul_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0000_0000, 1'b0, 0);
`ifdef MULTDIV_DIV_EN
    do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    do_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000, 1'b0, 0);
    do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0);
    do_op("div_prior", 1'b1, 32'h0000_0451, 32'h0000_0020, 34, 32'h0000_0011, 32'h0000_0022, 1'b0, 0);
    do_op("div_by0", 1'b1, 32'd5, 32'd0, 1, 32'h0000_0011, 32'h0000_0022, 1'b1, 0);
`else
    do_op("div_off", 1'b1, 32'd9, 32'd3, 1, 32'h4000_0000, 32'h0000_0000, 1'b0, 0);
`endif

    op = 1'b0; a = 32'h0000_1234; b = 32'h0000_5678; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midreset busy", {63'd0, busy}, 64'd0);
    check("midreset hilo", {hi, lo}, 64'd0);
    pulses = 0;
    repeat (40) begin
      if (done) pulses++;
      @(posedge clock); #1;
    end
    check("midreset no_done", 64'(pulses), 64'd0);

    do_op("mul_3_4", 1'b0, 32'd3, 32'd4, 33, 32'h0000_0000, 32'h0000_000C, 1'b0, 5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock, `clock`; reset is synchronous and active-high, named `reset`.
REQ-002 The block SHALL have parameter WIDTH, default 32: the operand width and the width of each of hi/lo.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request from the control FSM, sampled only in IDLE
- op  in  1  0=MULT, 1=DIV (the MDcontrol encoding)
- a  in  WIDTH  rs operand (multiplicand / dividend), signed
- b  in  WIDTH  rt operand (multiplier / divisor), signed
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; hi/lo are valid in the same cycle
- div0  out  1  one-cycle pulse, coincident with done, when a DIV has b==0

Function
REQ-004 States SHALL be IDLE, MULT, DIV, FIXUP and DONE; the iteration counter SHALL be 6 bits.
REQ-005 In IDLE with start=1 at edge N, a, b and op SHALL be latched, busy SHALL rise and the counter SHALL clear.
- op=0: go to MULT.
- op=1 and b!=0: go to DIV.
- op=1 and b==0: go to DONE.
REQ-006 Operand changes after edge N SHALL NOT affect the result.
REQ-007 MULT SHALL run signed radix-2 Booth for exactly WIDTH cycles (N+1..N+32), then go to DONE at N+33.
REQ-008 MULT SHALL produce {hi,lo} = the signed 64-bit product.
REQ-009 DIV SHALL run restoring division on operand magnitudes for WIDTH cycles (N+1..N+32).
REQ-010 FIXUP (N+33) SHALL apply the signs, then go to DONE at N+34:
- quotient truncates toward zero;
- remainder takes the sign of the dividend.
REQ-011 DIV results SHALL be lo = quotient and hi = remainder.
REQ-012 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, with no flag.
REQ-013 Divide by zero SHALL assert done=1 and div0=1 at N+1, leave hi/lo unchanged and perform no iterations.
REQ-014 hi and lo SHALL change only on the edge that enters DONE; between operations they hold their last values.
REQ-015 DONE SHALL last exactly one cycle (done=1, busy=0) and then return to IDLE.
REQ-016 A start asserted in DONE SHALL be ignored; the earliest next accepted start is the first IDLE cycle.
REQ-017 start SHALL be ignored in MULT, DIV, FIXUP and DONE; no queueing, no abort.
REQ-018 busy SHALL be 1 exactly in MULT, DIV and FIXUP.

Reset
REQ-019 When reset=1 at a clock edge, the block SHALL go to IDLE and clear hi, lo, busy, done, div0 and the counter to 0, from any state, including mid-operation.
REQ-020 reset SHALL take priority over start in the same cycle; a start coincident with reset SHALL be dropped.

Configuration
REQ-021 With macro MULTDIV_DIV_EN defined, division hardware (DIV, FIXUP, div0) SHALL be present as specified above.
REQ-022 With MULTDIV_DIV_EN undefined, the division datapath SHALL be absent and div0 SHALL be tied to 0.
- A start with op=1 SHALL go directly to DONE at N+1 with hi/lo unchanged.
- MULT behaviour SHALL be identical in both builds.

Structure
REQ-023 Shared package multdiv_pkg SHALL hold:
- the state enum;
- the op encodings (OP_MULT=0, OP_DIV=1);
- the default width constant 32;
- the iteration count constant.
REQ-024 One sub-module, multdiv_addsub, SHALL be used.
- It is a (WIDTH+1)-bit adder/subtractor shared by the Booth and restoring steps.
- All control SHALL stay in mult_div_unit.

Verification
REQ-025 The bench SHALL cover these scenarios:
- MULT a=7, b=0xFFFFFFFD (-3) -> done at N+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high for 32 cycles.
- MULT a=b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001; operands changed at N+5 do not alter the result.
- DIV a=0xFFFFFFF9 (-7), b=2 -> done at N+34, lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=5, b=0 after a prior result hi=0x11, lo=0x22 -> done=div0=1 at N+1, hi=0x11, lo=0x22 unchanged.
- reset at N+10 of a MULT -> next cycle busy=0, hi=lo=0, no done pulse.
  - A new MULT 3*4 then gives hi=0, lo=12.
  - A start pulsed during busy is ignored.
- Build without MULTDIV_DIV_EN: DIV 9/3 -> done at N+1, div0=0, hi/lo unchanged.
